// File: rtl/mebx_onchip_memory_pipe_pkg.sv
// Shared types and elaboration helpers for the MebX on-chip RAM slave.
package mebx_onchip_mem_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    function automatic bit rl_legal(input int rl);
        return (rl == 1) || (rl == 2);
    endfunction

    function automatic int be_width(input int dw);
        return dw / 8;
    endfunction

    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/mebx_onchip_memory_pipe_if.sv
// Avalon-MM slave bundle for the MebX on-chip RAM.
interface mebx_onchip_memory_pipe_if
    import mebx_onchip_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 18,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]           address;
    logic [be_width(DATA_WIDTH)-1:0] byteenable;
    logic                            chipselect;
    logic                            read;
    logic                            write;
    logic [DATA_WIDTH-1:0]           writedata;
    logic [DATA_WIDTH-1:0]           readdata;
    logic                            readdatavalid;
    logic                            waitrequest;

    modport master (
        output address, byteenable, chipselect, read, write, writedata,
        input  readdata, readdatavalid, waitrequest
    );

    modport slave (
        input  address, byteenable, chipselect, read, write, writedata,
        output readdata, readdatavalid, waitrequest
    );
endinterface

// File: rtl/mebx_onchip_memory_pipe_ram.sv
// Inferred single-port RAM with byte lanes, registered read and clock enable.
module mebx_onchip_ram_core
    import mebx_onchip_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 208896,
    parameter int IW         = 18
) (
    input  logic                            clk,
    input  logic                            i_ce,
    input  logic                            i_we,
    input  logic [be_width(DATA_WIDTH)-1:0] i_be,
    input  logic [IW-1:0]                   i_addr,
    input  logic [DATA_WIDTH-1:0]           i_wdata,
    output logic [DATA_WIDTH-1:0]           o_q
);
    localparam int BW = be_width(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_q;

    always_ff @(posedge clk) begin
        if (i_ce) begin
            if (i_we) begin
                for (int b = 0; b < BW; b++) begin
                    if (i_be[b]) begin
                        r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
                    end
                end
            end
            r_q <= r_mem[i_addr];
        end
    end

    assign o_q = r_q;
endmodule

// File: rtl/mebx_onchip_memory_pipe.sv
// Avalon-MM on-chip RAM slave with pipelined reads and a fill/clear engine.
module mebx_onchip_memory_pipe
    import mebx_onchip_mem_pkg::*;
#(
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    DEPTH          = 208896,
    parameter int                    ADDR_WIDTH     = 18,
    parameter int                    READ_LATENCY   = 1,
    parameter int                    CLEAR_ON_RESET = 1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE     = '0
) (
    input  logic clk,
    input  logic reset,
    input  logic reset_req,
    input  logic clken,
    input  logic clear_req,
    output logic init_done,
    mebx_onchip_memory_pipe_if.slave bus
);
    localparam int BW = be_width(DATA_WIDTH);
    localparam int IW = idx_width(DEPTH);
    localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0] DEPTH_V = (ADDR_WIDTH + 1)'(DEPTH);
    localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;

    if (!rl_legal(READ_LATENCY)) begin : g_bad_rl
        $error("READ_LATENCY must be 1 or 2");
    end

    state_t                r_state;
    state_t                w_state_nxt;
    logic [IW-1:0]         r_ctr;
    logic                  r_init_done;
    logic                  w_en;
    logic                  w_wait;
    logic                  w_inrange;
    logic                  w_acc;
    logic                  w_acc_wr;
    logic                  w_acc_rd;
    logic                  w_ram_we;
    logic [BW-1:0]         w_ram_be;
    logic [IW-1:0]         w_ram_addr;
    logic [DATA_WIDTH-1:0] w_ram_wdata;
    logic [DATA_WIDTH-1:0] w_q;
    logic                  r_v1;
    logic                  r_oor1;
    logic [DATA_WIDTH-1:0] w_d1;
    logic                  w_vo;
    logic [DATA_WIDTH-1:0] w_do;
    logic                  w_rdv;
    logic [DATA_WIDTH-1:0] r_rd_last;

    assign w_en      = clken & ~reset_req;
    assign w_wait    = reset | (r_state == ST_CLEAR) | ~w_en;
    assign w_inrange = {1'b0, bus.address} < DEPTH_V;
    assign w_acc     = bus.chipselect & (bus.read | bus.write) & ~w_wait;
    assign w_acc_wr  = w_acc & bus.write;
    assign w_acc_rd  = w_acc & ~bus.write;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= RST_STATE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_en) begin
            unique case (r_state)
                ST_CLEAR: if (r_ctr == LAST) w_state_nxt = ST_RUN;
                ST_RUN:   if (clear_req) w_state_nxt = ST_CLEAR;
            endcase
        end
    end

    // RAM port is shared: the clear engine owns it for the whole CLEAR state
    always_comb begin
        w_ram_we    = w_acc_wr & w_inrange;
        w_ram_be    = bus.byteenable;
        w_ram_addr  = bus.address[IW-1:0];
        w_ram_wdata = bus.writedata;
        unique case (1'b1)
            (r_state == ST_CLEAR): begin
                w_ram_we    = ~reset;
                w_ram_be    = '1;
                w_ram_addr  = r_ctr;
                w_ram_wdata = INIT_VALUE;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ctr       <= '0;
            r_init_done <= 1'b0;
        end else begin
            r_init_done <= (w_state_nxt == ST_RUN);
            if (w_en) begin
                if (r_state == ST_CLEAR) begin
                    r_ctr <= (r_ctr == LAST) ? '0 : r_ctr + IW'(1);
                end else if (clear_req) begin
                    r_ctr <= '0;
                end
            end
        end
    end

    mebx_onchip_ram_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .IW         (IW)
    ) u_ram (
        .clk     (clk),
        .i_ce    (w_en),
        .i_we    (w_ram_we),
        .i_be    (w_ram_be),
        .i_addr  (w_ram_addr),
        .i_wdata (w_ram_wdata),
        .o_q     (w_q)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_v1   <= 1'b0;
            r_oor1 <= 1'b0;
        end else if (w_en) begin
            r_v1   <= w_acc_rd;
            r_oor1 <= ~w_inrange;
        end
    end

    assign w_d1 = r_oor1 ? '0 : w_q;

    if (READ_LATENCY == 2) begin : g_rl2
        logic                  r_v2;
        logic [DATA_WIDTH-1:0] r_d2;

        always_ff @(posedge clk) begin
            if (reset) begin
                r_v2 <= 1'b0;
                r_d2 <= '0;
            end else if (w_en) begin
                r_v2 <= r_v1;
                r_d2 <= w_d1;
            end
        end

        assign w_vo = r_v2;
        assign w_do = r_d2;
    end else begin : g_rl1
        assign w_vo = r_v1;
        assign w_do = w_d1;
    end

    // A stalled result stays in its stage and is shown once en returns
    assign w_rdv = w_vo & w_en & ~reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_last <= '0;
        end else if (w_rdv) begin
            r_rd_last <= w_do;
        end
    end

    assign bus.readdata      = w_rdv ? w_do : r_rd_last;
    assign bus.readdatavalid = w_rdv;
    assign bus.waitrequest   = w_wait;
    assign init_done         = r_init_done;
endmodule

// File: tb/tb_mebx_onchip_memory_pipe.sv
// Directed bench: two instances (read latency 1 and 2) share one stimulus.
module tb_mebx_onchip_memory_pipe;
    localparam logic [31:0] INIT = 32'hA5A5_A5A5;

    typedef struct {
        logic [31:0] d;
        int          c;
    } rsp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        reset_req = 1'b0;
    logic        clken = 1'b1;
    logic        clear_req = 1'b0;
    logic        cs = 1'b0;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [4:0]  addr = '0;
    logic [3:0]  be = '0;
    logic [31:0] wd = '0;
    logic        done1;
    logic        done2;
    int          cyc = 0;
    int          n_chk = 0;
    int          n_err = 0;
    rsp_t        q1[$];
    rsp_t        q2[$];

    always #5 clk = ~clk;

    mebx_onchip_memory_pipe_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) b1 ();
    mebx_onchip_memory_pipe_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) b2 ();

    assign b1.address    = addr;
    assign b1.byteenable = be;
    assign b1.chipselect = cs;
    assign b1.read       = rd;
    assign b1.write      = wr;
    assign b1.writedata  = wd;
    assign b2.address    = addr;
    assign b2.byteenable = be;
    assign b2.chipselect = cs;
    assign b2.read       = rd;
    assign b2.write      = wr;
    assign b2.writedata  = wd;

    mebx_onchip_memory_pipe #(
        .DATA_WIDTH(32), .DEPTH(16), .ADDR_WIDTH(5),
        .READ_LATENCY(1), .CLEAR_ON_RESET(1), .INIT_VALUE(INIT)
    ) u1 (
        .clk(clk), .reset(reset), .reset_req(reset_req), .clken(clken),
        .clear_req(clear_req), .init_done(done1), .bus(b1)
    );

    mebx_onchip_memory_pipe #(
        .DATA_WIDTH(32), .DEPTH(16), .ADDR_WIDTH(5),
        .READ_LATENCY(2), .CLEAR_ON_RESET(1), .INIT_VALUE(INIT)
    ) u2 (
        .clk(clk), .reset(reset), .reset_req(reset_req), .clken(clken),
        .clear_req(clear_req), .init_done(done2), .bus(b2)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (b1.readdatavalid) q1.push_back('{b1.readdata, cyc});
        if (b2.readdatavalid) q2.push_back('{b2.readdata, cyc});
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic op(input logic w, input logic r, input logic [4:0] a,
                      input logic [3:0] b, input logic [31:0] d);
        cs = 1'b1; wr = w; rd = r; addr = a; be = b; wd = d;
        tick();
    endtask

    task automatic idle(input int n);
        cs = 1'b0; wr = 1'b0; rd = 1'b0;
        repeat (n) tick();
    endtask

    task automatic wait_clear(input string tag);
        int n;
        n = 0;
        #1;
        while (b1.waitrequest && n < 40) begin
            n++;
            tick();
        end
        chk({tag, "_wait"}, n, 16);
        chk({tag, "_done1"}, done1, 1'b1);
        chk({tag, "_done2"}, done2, 1'b1);
    endtask

    task automatic read_all(input string tag, input logic [31:0] exp);
        int bad;
        q1.delete();
        q2.delete();
        for (int a = 0; a < 16; a++) op(1'b0, 1'b1, 5'(a), 4'h0, '0);
        idle(4);
        chk({tag, "_n1"}, q1.size(), 16);
        chk({tag, "_n2"}, q2.size(), 16);
        bad = 0;
        foreach (q1[i]) if (q1[i].d !== exp) bad++;
        foreach (q2[i]) if (q2[i].d !== exp) bad++;
        chk({tag, "_data"}, bad, 0);
    endtask

    initial begin
        int c0;
        int s;
        int bad;

        // reset and power-on fill
        tick();
        tick();
        chk("rst_wait", b1.waitrequest, 1'b1);
        chk("rst_rdv", b1.readdatavalid, 1'b0);
        chk("rst_rdata1", b1.readdata, 32'h0);
        chk("rst_rdata2", b2.readdata, 32'h0);
        chk("rst_done", done1, 1'b0);
        reset = 1'b0;
        wait_clear("por");
        read_all("por", INIT);

        // partial byte write, then immediate read back
        q1.delete();
        q2.delete();
        op(1'b1, 1'b0, 5'd3, 4'b0101, 32'h1122_3344);
        c0 = cyc;
        op(1'b0, 1'b1, 5'd3, 4'h0, '0);
        idle(3);
        chk("be_n1", q1.size(), 1);
        chk("be_n2", q2.size(), 1);
        chk("be_d1", q1[0].d, 32'hA522_A544);
        chk("be_d2", q2[0].d, 32'hA522_A544);
        chk("be_lat1", q1[0].c - c0, 1);
        chk("be_lat2", q2[0].c - c0, 2);
        chk("hold_rdv", b1.readdatavalid, 1'b0);
        chk("hold_rdata", b1.readdata, 32'hA522_A544);

        // burst of 8 reads with a 3-cycle clken stall
        for (int a = 8; a < 16; a++) op(1'b1, 1'b0, 5'(a), 4'hF, 32'h100 + a);
        q1.delete();
        q2.delete();
        s = 0;
        for (int i = 0; i < 8; i++) begin
            if (i == 4) begin
                cs = 1'b1; rd = 1'b1; wr = 1'b0; addr = 5'd12;
                clken = 1'b0;
                s = cyc;
                repeat (3) tick();
                clken = 1'b1;
            end
            op(1'b0, 1'b1, 5'(8 + i), 4'h0, '0);
        end
        idle(4);
        chk("stall_n1", q1.size(), 8);
        chk("stall_n2", q2.size(), 8);
        bad = 0;
        foreach (q1[i]) begin
            if (q1[i].d !== 32'h108 + i) bad++;
            if (q1[i].c >= s && q1[i].c <= s + 2) bad++;
        end
        chk("stall_u1", bad, 0);
        bad = 0;
        foreach (q2[i]) begin
            if (q2[i].d !== 32'h108 + i) bad++;
            if (q2[i].c >= s && q2[i].c <= s + 2) bad++;
        end
        chk("stall_u2", bad, 0);

        // clear request with two reads in flight
        q1.delete();
        q2.delete();
        op(1'b0, 1'b1, 5'd8, 4'h0, '0);
        clear_req = 1'b1;
        op(1'b0, 1'b1, 5'd9, 4'h0, '0);
        clear_req = 1'b0;
        cs = 1'b0; rd = 1'b0;
        wait_clear("clr");
        chk("clr_n2", q2.size(), 2);
        chk("clr_d2a", q2[0].d, 32'h108);
        chk("clr_d2b", q2[1].d, 32'h109);
        chk("clr_n1", q1.size(), 2);
        chk("clr_d1b", q1[1].d, 32'h109);
        read_all("clr", INIT);

        // out-of-range access
        op(1'b1, 1'b0, 5'd20, 4'hF, 32'hDEAD_BEEF);
        q1.delete();
        q2.delete();
        c0 = cyc;
        op(1'b0, 1'b1, 5'd20, 4'h0, '0);
        op(1'b0, 1'b1, 5'd4, 4'h0, '0);
        idle(3);
        chk("oor_n1", q1.size(), 2);
        chk("oor_d1", q1[0].d, 32'h0);
        chk("oor_lat1", q1[0].c - c0, 1);
        chk("oor_d2", q2[0].d, 32'h0);
        chk("oor_lat2", q2[0].c - c0, 2);
        chk("oor_a4_1", q1[1].d, INIT);
        chk("oor_a4_2", q2[1].d, INIT);

        // reset in the middle of a clear
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (7) tick();
        chk("mid_done", done1, 1'b0);
        reset = 1'b1;
        #1;
        chk("mid_wait", b1.waitrequest, 1'b1);
        tick();
        reset = 1'b0;
        wait_clear("rst7");

        // simultaneous read and write
        q1.delete();
        q2.delete();
        op(1'b1, 1'b1, 5'd5, 4'hF, 32'h0000_00FF);
        idle(3);
        chk("rw_n1", q1.size(), 0);
        chk("rw_n2", q2.size(), 0);
        op(1'b0, 1'b1, 5'd5, 4'h0, '0);
        idle(3);
        chk("rw_d1", q1[0].d, 32'h0000_00FF);
        chk("rw_d2", q2[0].d, 32'h0000_00FF);

        // reset_req stalls like clken=0
        q1.delete();
        q2.delete();
        reset_req = 1'b1;
        cs = 1'b1; rd = 1'b1; addr = 5'd5;
        #1;
        chk("rreq_wait", b1.waitrequest, 1'b1);
        tick();
        tick();
        reset_req = 1'b0;
        idle(3);
        chk("rreq_n1", q1.size(), 0);
        chk("rreq_n2", q2.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
